// File: rtl/step_sequencer.sv
// ---------------------------------------------------------------------------
// step_sequencer
//
// Pattern store and playback engine for the drum machine. Sits directly
// downstream of the mode controller and follows its 2-bit mode:
//   EDIT (00) : pad pulses toggle pattern bits at the cursor step, the
//               cursor moves with step_inc / step_dec, clear wipes the
//               whole pattern, and pads are auditioned on the triggers.
//   PLAY (01) : steps through the pattern at a fixed tempo and fires the
//               stored column on the triggers once per step.
//   RAW  (10) : pads pass straight through to the triggers.
//   11        : reserved; triggers silent and all state holds.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_mode       operating mode from the mode controller
//   i_pad        one-cycle debounced pad pulses, bit t = track t
//   i_step_inc   one-cycle pulse, cursor +1 (EDIT only)
//   i_step_dec   one-cycle pulse, cursor -1 (EDIT only)
//   i_clear      one-cycle pulse, zero the entire pattern (EDIT only)
//   o_trig       registered one-cycle trigger pulses to the voices
//   o_step_idx   play position in PLAY, edit cursor otherwise
//   o_step_col   pattern column at o_step_idx, for the step LEDs
// ---------------------------------------------------------------------------
module step_sequencer #(
  parameter int STEPS          = 16,
  parameter int TRACKS         = 4,
  parameter int TICKS_PER_STEP = 6250000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [1:0]               i_mode,
  input  logic [TRACKS-1:0]        i_pad,
  input  logic                     i_step_inc,
  input  logic                     i_step_dec,
  input  logic                     i_clear,
  output logic [TRACKS-1:0]        o_trig,
  output logic [$clog2(STEPS)-1:0] o_step_idx,
  output logic [TRACKS-1:0]        o_step_col
);

  localparam int SW = $clog2(STEPS);
  localparam int TW = $clog2(TICKS_PER_STEP);

  // A TW-bit counter always reaches TICKS_PER_STEP-1 because
  // clog2(N) bits hold every value up to N-1.
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_STEP - 1);

  typedef enum logic [1:0] {
    MODE_EDIT = 2'b00,
    MODE_PLAY = 2'b01,
    MODE_RAW  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  // Registered state
  logic [STEPS-1:0]  r_pattern [TRACKS];
  logic [SW-1:0]     r_cursor;
  logic [SW-1:0]     r_play_pos;
  logic [TW-1:0]     r_tick;
  mode_t             r_prev_mode;
  logic [TRACKS-1:0] r_trig;

  // Next-state values
  logic [STEPS-1:0]  w_pattern_nxt [TRACKS];
  logic [SW-1:0]     w_cursor_nxt;
  logic [SW-1:0]     w_play_pos_nxt;
  logic [TW-1:0]     w_tick_nxt;
  logic [TRACKS-1:0] w_trig_nxt;

  // Helpers
  mode_t             w_mode;
  logic              w_play_entry;
  logic [SW-1:0]     w_pos_inc;
  logic [SW-1:0]     w_view_idx;
  logic [TRACKS-1:0] w_col_first;
  logic [TRACKS-1:0] w_col_next;
  logic [TRACKS-1:0] w_col_view;

  assign w_mode       = mode_t'(i_mode);
  assign w_play_entry = (w_mode == MODE_PLAY) && (r_prev_mode != MODE_PLAY);

  // STEPS is a power of two, so the natural SW-bit overflow is the wrap.
  assign w_pos_inc  = r_play_pos + SW'(1);

  // The display follows the live mode input, so it switches to the play
  // position in the same cycle PLAY is selected (before the restart lands).
  assign w_view_idx = (w_mode == MODE_PLAY) ? r_play_pos : r_cursor;

  // Column slices: step 0 for PLAY entry, the upcoming step for the step
  // boundary, and the displayed step for the LEDs.
  always_comb begin
    w_col_first = '0;
    w_col_next  = '0;
    w_col_view  = '0;
    for (int t = 0; t < TRACKS; t++) begin
      w_col_first[t] = r_pattern[t][0];
      w_col_next[t]  = r_pattern[t][w_pos_inc];
      w_col_view[t]  = r_pattern[t][w_view_idx];
    end
  end

  // Next-state logic for every mode. Defaults hold the pattern, cursor and
  // play position, park the tick counter at 0 and keep the triggers silent;
  // each mode then overrides only what it owns.
  always_comb begin
    for (int t = 0; t < TRACKS; t++) begin
      w_pattern_nxt[t] = r_pattern[t];
    end
    w_cursor_nxt   = r_cursor;
    w_play_pos_nxt = r_play_pos;
    w_tick_nxt     = '0;
    w_trig_nxt     = '0;

    case (w_mode)
      MODE_EDIT: begin
        w_trig_nxt = i_pad;
        // Toggles use the cursor as it was at the start of the cycle, so a
        // simultaneous move affects only where the next press lands.
        if (i_clear) begin
          for (int t = 0; t < TRACKS; t++) begin
            w_pattern_nxt[t] = '0;
          end
        end else begin
          for (int t = 0; t < TRACKS; t++) begin
            if (i_pad[t]) begin
              w_pattern_nxt[t][r_cursor] = ~r_pattern[t][r_cursor];
            end
          end
        end
        if (i_step_inc && !i_step_dec) begin
          w_cursor_nxt = r_cursor + SW'(1);
        end else if (i_step_dec && !i_step_inc) begin
          w_cursor_nxt = r_cursor - SW'(1);
        end
      end

      MODE_PLAY: begin
        if (w_play_entry) begin
          // Entering PLAY always restarts from step 0 and fires it at once.
          w_play_pos_nxt = '0;
          w_tick_nxt     = '0;
          w_trig_nxt     = w_col_first;
        end else if (r_tick == TICK_LAST) begin
          w_play_pos_nxt = w_pos_inc;
          w_tick_nxt     = '0;
          w_trig_nxt     = w_col_next;
        end else begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end

      MODE_RAW: begin
        w_trig_nxt = i_pad;
      end

      default: begin
      end
    endcase
  end

  // State register with synchronous reset. Reset clears prev_mode to EDIT
  // so that a PLAY request on the first cycle out of reset is an entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int t = 0; t < TRACKS; t++) begin
        r_pattern[t] <= '0;
      end
      r_cursor    <= '0;
      r_play_pos  <= '0;
      r_tick      <= '0;
      r_prev_mode <= MODE_EDIT;
      r_trig      <= '0;
    end else begin
      for (int t = 0; t < TRACKS; t++) begin
        r_pattern[t] <= w_pattern_nxt[t];
      end
      r_cursor    <= w_cursor_nxt;
      r_play_pos  <= w_play_pos_nxt;
      r_tick      <= w_tick_nxt;
      r_prev_mode <= w_mode;
      r_trig      <= w_trig_nxt;
    end
  end

  assign o_trig     = r_trig;
  assign o_step_idx = w_view_idx;
  assign o_step_col = w_col_view;

endmodule
